// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer
// Description : Command sequencer that expands FILL / COPY / ALU commands into
//               a stream of datapath control words, one per clock.
//               FILL : write cmd_imm+i into R[cmd_da+i], i = 0..cmd_count
//               COPY : copy R[cmd_aa] into R[cmd_da+i], i = 0..cmd_count
//               ALU  : single word R[cmd_da] = F(R[cmd_aa], R[cmd_ba] or K)
//               Reserved op completes immediately with a sticky error.
// Ports       : clk, rst_n            clock, async active-low reset
//               i_cmd_*               command handshake and fields
//               o_cmd_ready           high only while idle
//               o_write .. o_k        registered datapath control word
//               o_busy/o_done/o_err   status (busy, completion pulse, error)
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [4:0]  i_cmd_fs,
    input  logic [4:0]  i_cmd_aa,
    input  logic [4:0]  i_cmd_ba,
    input  logic [4:0]  i_cmd_da,
    input  logic [4:0]  i_cmd_count,
    input  logic [63:0] i_cmd_imm,
    input  logic        i_cmd_bsel,
    output logic        o_write,
    output logic        o_bselect,
    output logic        o_en_b,
    output logic        o_en_alu,
    output logic        o_cin,
    output logic [4:0]  o_fs,
    output logic [4:0]  o_aa,
    output logic [4:0]  o_ba,
    output logic [4:0]  o_da,
    output logic [63:0] o_k,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [1:0] C_OP_FILL = 2'b00;
    localparam logic [1:0] C_OP_COPY = 2'b01;
    localparam logic [1:0] C_OP_ALU  = 2'b10;
    localparam logic [1:0] C_OP_RSV  = 2'b11;

    // FS code that routes the B operand (K) straight through the ALU
    localparam logic [4:0] C_FS_PASS_B = 5'b01000;
    localparam logic [4:0] C_R31       = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic        bselect;
        logic        en_b;
        logic        en_alu;
        logic        cin;
        logic [4:0]  fs;
        logic [4:0]  aa;
        logic [4:0]  ba;
        logic [4:0]  da;
        logic [63:0] k;
    } ctrl_t;

    localparam ctrl_t C_IDLE_CTRL = '0;

    // Builds control word number idx of a command. Destination and K
    // increments wrap naturally at their field widths.
    function automatic ctrl_t make_word(
        input logic [1:0]  op,
        input logic [4:0]  fs,
        input logic [4:0]  aa,
        input logic [4:0]  ba,
        input logic [4:0]  da,
        input logic [63:0] imm,
        input logic        bsel,
        input logic [4:0]  idx
    );
        ctrl_t w;
        w        = '0;
        w.en_alu = 1'b1;
        case (op)
            C_OP_ALU: begin
                w.fs      = fs;
                w.aa      = aa;
                w.ba      = ba;
                w.bselect = bsel;
                w.da      = da;
                w.k       = imm;
            end
            C_OP_COPY: begin
                w.fs      = C_FS_PASS_B;
                w.aa      = aa;
                w.bselect = 1'b1;
                w.da      = da + idx;
                w.k       = '0;
            end
            default: begin
                w.fs      = C_FS_PASS_B;
                w.aa      = C_R31;
                w.bselect = 1'b1;
                w.da      = da + idx;
                w.k       = imm + {59'd0, idx};
            end
        endcase
        // R31 is read-only: the word still goes out, but without the write
        w.write = (w.da != C_R31);
        return w;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_op;
    logic [4:0]  r_fs, r_aa, r_ba, r_da, r_count, r_idx, w_idx_nxt;
    logic [63:0] r_imm;
    logic        r_bsel;
    logic        w_latch;
    ctrl_t       r_ctrl, w_ctrl_nxt;
    logic        r_busy, r_done, r_err, r_ready, w_err_nxt;

    // State register plus all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_ctrl  <= C_IDLE_CTRL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_err   <= w_err_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Command field capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_fs    <= '0;
            r_aa    <= '0;
            r_ba    <= '0;
            r_da    <= '0;
            r_count <= '0;
            r_imm   <= '0;
            r_bsel  <= 1'b0;
        end else if (w_latch) begin
            r_op    <= i_cmd_op;
            r_fs    <= i_cmd_fs;
            r_aa    <= i_cmd_aa;
            r_ba    <= i_cmd_ba;
            r_da    <= i_cmd_da;
            r_count <= i_cmd_count;
            r_imm   <= i_cmd_imm;
            r_bsel  <= i_cmd_bsel;
        end
    end

    // Next-state and next control word. The word computed here is the one
    // that becomes visible after the coming edge, so word 0 is built from
    // the live command inputs and later words from the captured fields.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ctrl_nxt  = C_IDLE_CTRL;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_latch   = 1'b1;
                    w_idx_nxt = '0;
                    w_err_nxt = (i_cmd_op == C_OP_RSV);
                    if (i_cmd_op == C_OP_RSV) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_ctrl_nxt  = make_word(i_cmd_op, i_cmd_fs, i_cmd_aa,
                                                i_cmd_ba, i_cmd_da, i_cmd_imm,
                                                i_cmd_bsel, 5'd0);
                    end
                end
            end
            S_ISSUE: begin
                if ((r_op == C_OP_ALU) || (r_idx == r_count)) begin
                    w_state_nxt = S_DONE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt  = r_idx + 5'd1;
                    w_ctrl_nxt = make_word(r_op, r_fs, r_aa, r_ba, r_da,
                                           r_imm, r_bsel, r_idx + 5'd1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_cmd_ready = r_ready;
    assign o_write     = r_ctrl.write;
    assign o_bselect   = r_ctrl.bselect;
    assign o_en_b      = r_ctrl.en_b;
    assign o_en_alu    = r_ctrl.en_alu;
    assign o_cin       = r_ctrl.cin;
    assign o_fs        = r_ctrl.fs;
    assign o_aa        = r_ctrl.aa;
    assign o_ba        = r_ctrl.ba;
    assign o_da        = r_ctrl.da;
    assign o_k         = r_ctrl.k;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_sequencer
// Description : Self-checking bench for datapath_sequencer. Per-cycle rows of
//               {command inputs, expected registered outputs} are applied and
//               compared one clock at a time; reset abort is hand-sequenced.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_fs, cmd_aa, cmd_ba, cmd_da, cmd_count;
    logic [63:0] cmd_imm;
    logic        cmd_bsel;
    logic        write_o, bselect_o, en_b_o, en_alu_o, cin_o;
    logic [4:0]  fs_o, aa_o, ba_o, da_o;
    logic [63:0] k_o;
    logic        busy_o, done_o, err_o;

    datapath_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_fs    (cmd_fs),
        .i_cmd_aa    (cmd_aa),
        .i_cmd_ba    (cmd_ba),
        .i_cmd_da    (cmd_da),
        .i_cmd_count (cmd_count),
        .i_cmd_imm   (cmd_imm),
        .i_cmd_bsel  (cmd_bsel),
        .o_write     (write_o),
        .o_bselect   (bselect_o),
        .o_en_b      (en_b_o),
        .o_en_alu    (en_alu_o),
        .o_cin       (cin_o),
        .o_fs        (fs_o),
        .o_aa        (aa_o),
        .o_ba        (ba_o),
        .o_da        (da_o),
        .o_k         (k_o),
        .o_busy      (busy_o),
        .o_done      (done_o),
        .o_err       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready,busy,done,err,write,bsel,en_b,en_alu,cin,fs,aa,ba,da,k}
    wire [92:0] w_act = {cmd_ready, busy_o, done_o, err_o, write_o, bselect_o,
                         en_b_o, en_alu_o, cin_o, fs_o, aa_o, ba_o, da_o, k_o};

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [4:0]  fs, aa, ba, da, cnt;
        logic [63:0] imm;
        logic        bsel;
        logic [92:0] exp;
    } row_t;

    row_t        rows[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          row_no = 0;

    logic        c_valid;
    logic [1:0]  c_op;
    logic [4:0]  c_fs, c_aa, c_ba, c_da, c_cnt;
    logic [63:0] c_imm;
    logic        c_bsel;

    function automatic logic [92:0] pk(
        input logic rdy, input logic bsy, input logic dn, input logic er,
        input logic wr, input logic bs, input logic ea,
        input logic [4:0] fs, input logic [4:0] aa, input logic [4:0] ba,
        input logic [4:0] da, input logic [63:0] k);
        return {rdy, bsy, dn, er, wr, bs, 1'b0, ea, 1'b0, fs, aa, ba, da, k};
    endfunction

    function automatic void cmd(
        input logic v, input logic [1:0] op, input logic [4:0] fs,
        input logic [4:0] aa, input logic [4:0] ba, input logic [4:0] da,
        input logic [4:0] cnt, input logic [63:0] imm, input logic bsel);
        c_valid = v; c_op = op; c_fs = fs; c_aa = aa; c_ba = ba;
        c_da = da; c_cnt = cnt; c_imm = imm; c_bsel = bsel;
    endfunction

    function automatic void noc();
        c_valid = 1'b0;
    endfunction

    function automatic void push(input logic [92:0] e);
        row_t r;
        r.valid = c_valid; r.op = c_op; r.fs = c_fs; r.aa = c_aa;
        r.ba = c_ba; r.da = c_da; r.cnt = c_cnt; r.imm = c_imm;
        r.bsel = c_bsel; r.exp = e;
        rows.push_back(r);
    endfunction

    function automatic void word(
        input logic er, input logic wr, input logic bs, input logic [4:0] fs,
        input logic [4:0] aa, input logic [4:0] ba, input logic [4:0] da,
        input logic [63:0] k);
        push(pk(1'b0, 1'b1, 1'b0, er, wr, bs, 1'b1, fs, aa, ba, da, k));
    endfunction

    function automatic void done_r(input logic er);
        push(pk(1'b0, 1'b1, 1'b1, er, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0));
    endfunction

    function automatic void idle_r(input logic er);
        push(pk(1'b1, 1'b0, 1'b0, er, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0));
    endfunction

    task automatic chk(input string name, input logic [92:0] e);
        n_cmp++;
        if (w_act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, w_act, e);
        end
    endtask

    // Drive each queued row, clock once, compare after the edge
    task automatic run_rows();
        foreach (rows[j]) begin
            cmd_valid = rows[j].valid; cmd_op = rows[j].op;
            cmd_fs = rows[j].fs; cmd_aa = rows[j].aa; cmd_ba = rows[j].ba;
            cmd_da = rows[j].da; cmd_count = rows[j].cnt;
            cmd_imm = rows[j].imm; cmd_bsel = rows[j].bsel;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", row_no), rows[j].exp);
            row_no++;
        end
        rows.delete();
    endtask

    localparam logic [1:0]  FILL = 2'b00, COPY = 2'b01, ALU = 2'b10, RSV = 2'b11;
    localparam logic [4:0]  PASS = 5'b01000;
    localparam logic [92:0] IDLE_OUT = {1'b1, 92'd0};

    initial begin
        rst_n = 1'b1;
        cmd(1'b0, FILL, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
        cmd_valid = 0; cmd_op = 0; cmd_fs = 0; cmd_aa = 0; cmd_ba = 0;
        cmd_da = 0; cmd_count = 0; cmd_imm = 0; cmd_bsel = 0;
        #1 rst_n = 1'b0;
        #3;
        chk("reset_state", IDLE_OUT);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // FILL da=0 count=3 imm=0: accepted on the first edge after release
        cmd(1'b1, FILL, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 64'd0, 1'b0);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd0, 64'd0);
        noc();
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd1, 64'd1);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd2, 64'd2);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd3, 64'd3);
        done_r(0);
        idle_r(0);

        // FILL across R31 and 64-bit wrap
        cmd(1'b1, FILL, 5'd0, 5'd0, 5'd0, 5'd30, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd30, 64'hFFFF_FFFF_FFFF_FFFE);
        noc();
        word(0, 0, 1, PASS, 5'd31, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd0, 64'd0);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd1, 64'd1);
        done_r(0);
        idle_r(0);

        // ALU single word, count=31 must not stretch it
        cmd(1'b1, ALU, 5'b00101, 5'd2, 5'd3, 5'd4, 5'd31, 64'h1234, 1'b0);
        word(0, 1, 0, 5'b00101, 5'd2, 5'd3, 5'd4, 64'h1234);
        noc();
        done_r(0);
        idle_r(0);

        // Reserved op: straight to DONE with sticky err, cleared by next FILL
        cmd(1'b1, RSV, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 64'd9, 1'b0);
        done_r(1);
        noc();
        idle_r(1);
        idle_r(1);
        cmd(1'b1, FILL, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 64'd7, 1'b0);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd5, 64'd7);
        noc();
        done_r(0);
        idle_r(0);

        // COPY with cmd_valid held high; the ALU behind it waits for IDLE
        cmd(1'b1, COPY, 5'd0, 5'd9, 5'd0, 5'd10, 5'd1, 64'hABC, 1'b0);
        word(0, 1, 1, PASS, 5'd9, 5'd0, 5'd10, 64'd0);
        cmd(1'b1, ALU, 5'd1, 5'd2, 5'd3, 5'd6, 5'd0, 64'h55, 1'b1);
        word(0, 1, 1, PASS, 5'd9, 5'd0, 5'd11, 64'd0);
        done_r(0);
        idle_r(0);
        word(0, 1, 1, 5'd1, 5'd2, 5'd3, 5'd6, 64'h55);
        noc();
        done_r(0);
        idle_r(0);
        run_rows();

        // Reset during the 3rd word of a FILL count=7
        cmd(1'b1, FILL, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 64'h100, 1'b0);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd0, 64'h100);
        noc();
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd1, 64'h101);
        word(0, 1, 1, PASS, 5'd31, 5'd0, 5'd2, 64'h102);
        run_rows();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", IDLE_OUT);
        @(posedge clk);
        #1;
        chk("reset_hold", IDLE_OUT);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release", IDLE_OUT);

        cmd(1'b1, COPY, 5'd0, 5'd7, 5'd0, 5'd3, 5'd1, 64'hFF, 1'b0);
        word(0, 1, 1, PASS, 5'd7, 5'd0, 5'd3, 64'd0);
        noc();
        word(0, 1, 1, PASS, 5'd7, 5'd0, 5'd4, 64'd0);
        done_r(0);
        idle_r(0);
        idle_r(0);
        run_rows();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clock.
REQ-003 cmd_valid  in  1  command present.
REQ-004 cmd_ready  out  1  high only in IDLE; a command is accepted on a clock edge where cmd_valid=1 and cmd_ready=1.
REQ-005 cmd_op  in  2  00 FILL, 01 COPY, 10 ALU, 11 reserved.
REQ-006 cmd_fs  in  5  ALU function select, used by ALU only.
REQ-007 cmd_aa, cmd_ba  in  5 each  source register addresses.
REQ-008 cmd_da  in  5  first destination register.
REQ-009 cmd_count  in  5  number of writes minus 1 (0..31); FILL/COPY only.
REQ-010 cmd_imm  in  64  immediate / FILL start value.
REQ-011 cmd_bsel  in  1  B-operand select for ALU (1 = K).
REQ-012 write, Bselect, EN_B, EN_ALU, cin  out  1 each  datapath control word bits.
REQ-013 FS  out  5;  AA, BA, DA  out  5 each;  K  out  64  datapath control word fields.
REQ-014 busy  out  1  high in ISSUE and DONE.
REQ-015 done  out  1  one-cycle pulse at command completion.
REQ-016 err  out  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, ISSUE, DONE; all outputs registered.
REQ-018 IDLE: control word at idle value (write=0, EN_ALU=0, EN_B=0, Bselect=0, cin=0, FS=AA=BA=DA=0, K=0); acceptance latches all cmd_* fields, clears err, sets index i=0, moves to ISSUE (op 00/01/10) or DONE (op 11).
REQ-019 ISSUE: one control word per cycle, visible in the cycle after the edge that entered or stayed in ISSUE.
REQ-020 FILL word i: write=1, FS=01000, AA=11111, BA=0, Bselect=1, EN_ALU=1, EN_B=0, cin=0, DA=cmd_da+i (mod 32), K=cmd_imm+i (mod 2^64).
REQ-021 COPY word i: as FILL except AA=cmd_aa, K=0.
REQ-022 ALU: exactly one word: write=1, FS=cmd_fs, AA=cmd_aa, BA=cmd_ba, Bselect=cmd_bsel, EN_ALU=1, EN_B=0, cin=0, DA=cmd_da, K=cmd_imm; cmd_count ignored.
REQ-023 FILL/COPY issue cmd_count+1 words, i=0..cmd_count, then move to DONE; ALU moves to DONE after 1 word.
REQ-024 DA wraps 31->0 within a command; K increments wrap modulo 2^64 without error.
REQ-025 Any word whose DA=31 is issued with write=0, all other fields unchanged (R31 protected); no error is raised.
REQ-026 DONE: control word at idle value, done=1 for exactly one cycle, then IDLE; cmd_ready returns high the cycle after done.
REQ-027 Reserved op: no ISSUE cycles, err=1 set on entering DONE, held until next accepted command.
REQ-028 cmd_valid while busy is ignored (not accepted, not queued).
REQ-029 Total latency: accept edge + (count+1) ISSUE cycles + 1 DONE cycle for FILL/COPY; accept + 1 + 1 for ALU.

Reset
REQ-030 reset=0 at any time (incl. mid-ISSUE): state=IDLE, control word at idle value, busy=0, done=0, err=0, cmd_ready=1, i=0, command aborted with no further writes.
REQ-031 After reset release, first acceptance possible on the next rising edge.

Verification
REQ-032 FILL da=0, count=3, imm=0 -> 4 cycles write=1, DA=0,1,2,3, K=0,1,2,3, FS=01000, AA=31, Bselect=1; then done pulse; total 5 cycles busy.
REQ-033 FILL da=30, count=3, imm=FFFF_FFFF_FFFF_FFFE -> DA=30,31,0,1; write=1,0,1,1; K=..FE,..FF,0,1.
REQ-034 ALU fs=00101, aa=2, ba=3, bsel=0, da=4 -> one word with those fields, write=1, EN_ALU=1; cmd_count=31 has no effect.
REQ-035 op=11 -> no write, done pulse next cycle, err=1 until next accepted FILL clears it.
REQ-036 reset low during 3rd FILL word of count=7 -> write drops to 0 asynchronously, idle outputs; new command accepted after release completes normally.
REQ-037 cmd_valid held high through a COPY -> second command accepted only in IDLE after done; no overlap of words.
